// File: rtl/fetch_pkg.sv
// Shared widths and the {instruction, pc} entry type for the fetch unit.
package fetch_pkg;

    localparam int unsigned ADR_W    = 10;
    localparam int unsigned INST_W   = 16;
    localparam int unsigned FQ_DEPTH = 2;
    localparam int unsigned PTR_W    = 1;
    localparam int unsigned CNT_W    = 2;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADR_W-1:0]  pc;
    } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch queue with flush; head and valid are registered so that
// they hold the last head value while the queue is empty.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  fq_entry_t        i_push_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_valid,
    output fq_entry_t        o_head
);

    fq_entry_t        r_mem [FQ_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_valid;
    fq_entry_t        r_head;

    fq_entry_t        w_mem_nxt [FQ_DEPTH];
    logic [PTR_W-1:0] w_wr_nxt;
    logic [PTR_W-1:0] w_rd_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    fq_entry_t        w_head_nxt;

    // Next head is looked up from next-state storage so a push into an
    // empty queue (or a push over the popped slot when full) shows up at once.
    always_comb begin
        w_mem_nxt = r_mem;
        w_wr_nxt  = r_wr_ptr;
        w_rd_nxt  = r_rd_ptr;
        if (i_push) begin
            w_mem_nxt[r_wr_ptr] = i_push_data;
            w_wr_nxt            = r_wr_ptr + PTR_W'(1);
        end
        if (i_pop) begin
            w_rd_nxt = r_rd_ptr + PTR_W'(1);
        end
        w_cnt_nxt = r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        if (i_flush) begin
            w_wr_nxt  = '0;
            w_rd_nxt  = '0;
            w_cnt_nxt = '0;
        end
        w_head_nxt = (w_cnt_nxt != '0) ? w_mem_nxt[w_rd_nxt] : r_head;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(FQ_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_head   <= '0;
        end else begin
            r_mem    <= w_mem_nxt;
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_cnt_nxt;
            r_valid  <= (w_cnt_nxt != '0);
            r_head   <= w_head_nxt;
        end
    end

    assign o_count = r_count;
    assign o_valid = r_valid;
    assign o_head  = r_head;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, fetch/redirect/halt control and a
// two-entry registered buffer towards decode.
module fetch_unit
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic [ADR_W-1:0]  im_adr,
    input  logic [INST_W-1:0] im_inst,
    input  logic              redirect,
    input  logic [ADR_W-1:0]  redirect_pc,
    input  logic              halt,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADR_W-1:0]  inst_pc
);

    logic [ADR_W-1:0] r_pc;

    logic             w_pop;
    logic             w_fetch;
    logic [ADR_W-1:0] w_pc_nxt;
    logic [CNT_W-1:0] w_count;
    logic             w_valid;
    fq_entry_t        w_head;
    fq_entry_t        w_push_data;

    // Redirect wins over halt and fetch; a pop in the redirect cycle still counts.
    always_comb begin
        w_pop       = w_valid && inst_ready;
        w_fetch     = !redirect && !halt && ((w_count < CNT_W'(FQ_DEPTH)) || w_pop);
        w_pc_nxt    = r_pc;
        w_push_data = '{inst: im_inst, pc: r_pc};
        if (redirect) begin
            w_pc_nxt = redirect_pc;
        end else if (w_fetch) begin
            w_pc_nxt = r_pc + ADR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pc_nxt;
        end
    end

    fetch_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_fetch),
        .i_pop       (w_pop),
        .i_flush     (redirect),
        .i_push_data (w_push_data),
        .o_count     (w_count),
        .o_valid     (w_valid),
        .o_head      (w_head)
    );

    assign im_adr     = r_pc;
    assign inst_valid = w_valid;
    assign inst       = w_head.inst;
    assign inst_pc    = w_head.pc;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk and rst (rst low = reset, not synchronised to clk).
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 im_adr  output  10  word address driven to the instruction memory; equals the internal PC.
REQ-005 im_inst  input  16  instruction returned combinationally by the instruction memory for im_adr in the same cycle.
REQ-006 redirect  input  1  branch/jump taken; flushes buffered instructions.
REQ-007 redirect_pc  input  10  target PC, sampled when redirect=1.
REQ-008 halt  input  1  level; while high, no new fetches are issued and buffered entries remain.
REQ-009 inst_valid  output  1  buffer head holds a valid instruction.
REQ-010 inst_ready  input  1  downstream decode accepts the head this cycle.
REQ-011 inst  output  16  head instruction word.
REQ-012 inst_pc  output  10  PC of the head instruction.

Function
REQ-013 The block SHALL hold a 10-bit PC and a 2-entry FIFO of {instruction, pc} pairs, with a 2-bit occupancy count in the range 0..2.
REQ-014 pop SHALL equal inst_valid AND inst_ready; inst_valid SHALL equal (count != 0).
REQ-015 fetch SHALL equal NOT redirect AND NOT halt AND (count < 2 OR pop).
REQ-016 On fetch, the FIFO SHALL push {im_inst, PC} and PC SHALL become PC+1 modulo 1024, so 1023 wraps to 0.
REQ-017 A simultaneous push and pop at count=2 SHALL leave count at 2 and preserve FIFO order.
REQ-018 On redirect, count SHALL become 0 and PC SHALL become redirect_pc at the edge; a pop in that cycle still completes, and no push occurs.
REQ-019 Redirect latency: redirect asserted in cycle N gives a target fetch in N+1 and inst_valid=1 with inst_pc=redirect_pc in N+2.
REQ-020 Redirect SHALL take priority over halt and fetch when asserted in the same cycle.
REQ-021 Halt SHALL NOT alter PC or count beyond pops; deasserting halt resumes fetching in the same cycle.
REQ-022 inst and inst_pc SHALL be driven from registered FIFO storage, with no combinational path from im_inst to inst.
REQ-023 When count=0, inst and inst_pc SHALL hold the last head value; consumers SHALL qualify them with inst_valid.

Reset
REQ-024 When rst=0: PC=0, count=0, FIFO pointers=0, storage=0, inst_valid=0, inst=0, inst_pc=0, im_adr=0, asynchronously.
REQ-025 Reset asserted mid-operation SHALL discard all buffered entries; the first fetch after release uses address 0.

Structure
REQ-026 Package fetch_pkg SHALL define ADR_W=10, INST_W=16, FQ_DEPTH=2 and the {inst, pc} entry typedef.
REQ-027 The FIFO SHALL be a sub-module fetch_fifo providing push, pop, flush, count and head outputs; PC and fetch logic live in fetch_unit.

Verification
REQ-028 Reset release with inst_ready=1 and an IM model returning inst=adr+100: inst_valid rises in cycle 2 and the bench sees inst_pc 0,1,2… with inst 100,101,102… one per cycle.
REQ-029 inst_ready=0 for 6 cycles: count saturates at 2, im_adr stops at 2, and on release entries for PCs 0,1,2 emerge in order with none lost or duplicated.
REQ-030 Redirect to 40 while count=2: the next cycle has inst_valid=0 and im_adr=40, then inst_pc=40 and inst=140 two cycles after redirect.
REQ-031 PC at 1022 with free flow: output PCs are 1022, 1023, 0, 1.
REQ-032 Halt high for 5 cycles at PC 7 with inst_ready=1: buffered entries drain, im_adr stays 7, and fetching resumes at 7 on deassert; redirect+halt together: PC takes redirect_pc.
REQ-033 rst pulsed low between clock edges while count=2: inst_valid=0 and im_adr=0 immediately, and the output stream restarts at PC 0.
